pheromone_evaporator: RTL and testbench
=======================================

PHEROMONE_EVAPORATOR -- requirements
Module: pheromone_evaporator

Interface
REQ-001 The module SHALL have parameter DECAY_SHIFT, default 3, meaning the per-sweep decay fraction is 2^-DECAY_SHIFT.
REQ-002 The module SHALL have parameter P_bits, default 8, meaning the pheromone cell width.
REQ-003 Port simClock, input, 1, SHALL be the single clock; all state is updated on its rising edge.
REQ-004 Port RESET_SIM_N, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port start, input, 1, SHALL request one full world sweep.
REQ-006 Port curX, input, X_bits, SHALL be the current scan X from the location stage.
REQ-007 Port curY, input, Y_bits, SHALL be the current scan Y from the location stage.
REQ-008 Port advance, output, 1, SHALL be a one-cycle pulse that steps the location stage.
REQ-009 Ports rd_req (output, 1), rd_ready (input, 1), rd_valid (input, 1) and rd_data (input, P_bits) SHALL form the pheromone-memory read channel.
REQ-010 Ports wr_en (output, 1), wr_x (output, X_bits), wr_y (output, Y_bits) and wr_data (output, P_bits) SHALL form the pheromone-memory write channel.
REQ-011 Port busy, output, 1, SHALL be high while a sweep is in progress.
REQ-012 Port done, output, 1, SHALL pulse for one cycle at the end of a sweep.
REQ-013 Port sweep_count, output, 16, SHALL count completed sweeps.

Function
REQ-014 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WRITE, ADV and FINISH.
REQ-015 IDLE->RD_REQ SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-016 In RD_REQ, rd_req SHALL be 1; the state SHALL be held until rd_ready=1, and curX/curY SHALL be latched in the same cycle as that handshake.
REQ-017 In RD_WAIT, rd_data SHALL be captured on rd_valid=1 and the FSM SHALL go to WRITE; rd_valid SHALL be ignored in all other states.
REQ-018 WRITE SHALL last one cycle with wr_en=1, wr_x/wr_y = latched coordinates and wr_data = decayed value.
REQ-019 Decay: p=0 SHALL give 0; for p>0 the result SHALL be p - max(p>>DECAY_SHIFT, 1), computed at P_bits width, never below 0 and never wrapping.
REQ-020 ADV SHALL last one cycle with advance=1, issued for every cell including the last, so the location stage wraps to (0,0).
REQ-021 ADV SHALL go to FINISH if the latched coordinates equal (X_MAX-1, Y_MAX-1), and to RD_REQ otherwise.
REQ-022 FINISH SHALL last one cycle with done=1 and sweep_count+1 (wrapping at 2^16), then go to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 The minimum cost per cell SHALL be 4 cycles when rd_ready is already high and rd_valid arrives on the next cycle.
REQ-025 All outputs SHALL be registered, and only one of rd_req, wr_en, advance or done SHALL be high in any cycle.
REQ-026 The location stage SHALL present updated coordinates within 1 cycle of advance; the RD_REQ entry cycle SHALL provide that settling time.

Reset
REQ-027 RESET_SIM_N=0 SHALL immediately force IDLE and clear advance, rd_req, wr_en, wr_x, wr_y, wr_data, busy, done, sweep_count and the latched data.
REQ-028 A reset mid-sweep SHALL abort the sweep with no further write, and a late rd_valid SHALL be ignored.

Structure
REQ-029 X_bits, Y_bits, X_MAX, Y_MAX, P_bits and the FSM state enum SHALL reside in the shared params package.
REQ-030 The decay arithmetic SHALL be a combinational sub-module named pheromone_decay.

Verification
REQ-031 p=200, DECAY_SHIFT=3 -> wr_data=175; p=5 -> 4; p=1 -> 0; p=0 -> 0, with wr_en still pulsed.
REQ-032 A 4x4 world with start pulsed once and ready/valid immediate SHALL give 16 writes, 16 advance pulses, one done pulse, 64 cycles from RD_REQ entry to done, and sweep_count=1.
REQ-033 rd_ready held low for 10 cycles SHALL keep rd_req high for 10 cycles, with no coordinate latch and no advance.
REQ-034 start re-pulsed during cell 5 SHALL have no effect: a single done pulse and sweep_count=1.
REQ-035 Reset asserted in RD_WAIT, followed by rd_valid 2 cycles later, SHALL give busy=0, no wr_en and sweep_count=0.
REQ-036 sweep_count preloaded via 65535 sweeps (or forced) plus one more sweep SHALL read 0.

Source files
------------

// File: rtl/pheromone_evaporator_pkg.sv
// Shared world geometry, pheromone width and evaporator FSM state type.
package pheromone_evaporator_pkg;

    localparam int X_MAX  = 4;
    localparam int Y_MAX  = 4;
    localparam int X_bits = (X_MAX > 1) ? $clog2(X_MAX) : 1;
    localparam int Y_bits = (Y_MAX > 1) ? $clog2(Y_MAX) : 1;
    localparam int P_bits = 8;

    localparam logic [X_bits-1:0] X_LAST = X_bits'(X_MAX - 1);
    localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(Y_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WRITE,
        ADV,
        FINISH
    } evap_state_e;

endpackage

// File: rtl/pheromone_evaporator_decay.sv
// Combinational evaporation of one cell: p - max(p >> DECAY_SHIFT, 1), zero stays zero.
module pheromone_decay #(
    parameter int P_bits      = 8,
    parameter int DECAY_SHIFT = 3
) (
    input  logic [P_bits-1:0] p_in,
    output logic [P_bits-1:0] p_out
);

    logic [P_bits-1:0] frac;
    logic [P_bits-1:0] step;

    // step never exceeds p_in when p_in > 0, so the subtraction cannot wrap
    always_comb begin
        frac  = p_in >> DECAY_SHIFT;
        step  = (frac == '0) ? P_bits'(1) : frac;
        p_out = (p_in == '0) ? '0 : (p_in - step);
    end

endmodule

// File: rtl/pheromone_evaporator.sv
// Sweeps every world cell once per start: read, decay, write back, step the location stage.
module pheromone_evaporator
    import pheromone_evaporator_pkg::*;
#(
    parameter int DECAY_SHIFT = 3,
    parameter int P_bits      = pheromone_evaporator_pkg::P_bits
) (
    input  logic              simClock,
    input  logic              RESET_SIM_N,
    input  logic              start,
    input  logic [X_bits-1:0] curX,
    input  logic [Y_bits-1:0] curY,
    output logic              advance,
    output logic              rd_req,
    input  logic              rd_ready,
    input  logic              rd_valid,
    input  logic [P_bits-1:0] rd_data,
    output logic              wr_en,
    output logic [X_bits-1:0] wr_x,
    output logic [Y_bits-1:0] wr_y,
    output logic [P_bits-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sweep_count
);

    evap_state_e       state_q, state_d;
    logic [X_bits-1:0] x_q, x_d;
    logic [Y_bits-1:0] y_q, y_d;
    logic [P_bits-1:0] wr_data_q, wr_data_d;
    logic [15:0]       sweep_count_q, sweep_count_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_en_q, wr_en_d;
    logic              advance_q, advance_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [P_bits-1:0] decayed;

    pheromone_decay #(
        .P_bits      (P_bits),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_decay (
        .p_in  (rd_data),
        .p_out (decayed)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        wr_data_d     = wr_data_q;
        sweep_count_d = sweep_count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (rd_ready) begin
                    x_d     = curX;
                    y_d     = curY;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // decay is taken straight off rd_data so wr_data leaves a flop
                if (rd_valid) begin
                    wr_data_d = decayed;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                state_d = ADV;
            end
            ADV: begin
                if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                    state_d       = FINISH;
                    sweep_count_d = sweep_count_q + 16'd1;
                end else begin
                    state_d = RD_REQ;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the next state so every output is a flop.
        rd_req_d  = (state_d == RD_REQ);
        wr_en_d   = (state_d == WRITE);
        advance_d = (state_d == ADV);
        done_d    = (state_d == FINISH);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge simClock or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            wr_data_q     <= '0;
            sweep_count_q <= '0;
            rd_req_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            advance_q     <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            wr_data_q     <= wr_data_d;
            sweep_count_q <= sweep_count_d;
            rd_req_q      <= rd_req_d;
            wr_en_q       <= wr_en_d;
            advance_q     <= advance_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign rd_req      = rd_req_q;
    assign wr_en       = wr_en_q;
    assign advance     = advance_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign wr_x        = x_q;
    assign wr_y        = y_q;
    assign wr_data     = wr_data_q;
    assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_pheromone_evaporator.sv
// Randomized bench: memory responder, location stage and a cell-level scoreboard of the sweep.
module tb_pheromone_evaporator;
    import pheromone_evaporator_pkg::*;

    localparam int SHIFT = 3;
    localparam int PW    = P_bits;
    localparam int CELLS = X_MAX * Y_MAX;

    logic              simClock = 1'b0;
    logic              RESET_SIM_N;
    logic              start;
    logic [X_bits-1:0] curX;
    logic [Y_bits-1:0] curY;
    logic              advance;
    logic              rd_req;
    logic              rd_ready;
    logic              rd_valid;
    logic [PW-1:0]     rd_data;
    logic              wr_en;
    logic [X_bits-1:0] wr_x;
    logic [Y_bits-1:0] wr_y;
    logic [PW-1:0]     wr_data;
    logic              busy;
    logic              done;
    logic [15:0]       sweep_count;

    pheromone_evaporator #(
        .DECAY_SHIFT (SHIFT),
        .P_bits      (PW)
    ) dut (
        .simClock    (simClock),
        .RESET_SIM_N (RESET_SIM_N),
        .start       (start),
        .curX        (curX),
        .curY        (curY),
        .advance     (advance),
        .rd_req      (rd_req),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .sweep_count (sweep_count)
    );

    always #5 simClock = ~simClock;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int decay_ref(input int p);
        int d;
        if (p == 0) return 0;
        d = p / (1 << SHIFT);
        if (d < 1) d = 1;
        return p - d;
    endfunction

    // world contents, location stage and responder state
    int mem [CELLS];
    int loc, hs_addr, vdelay, inject_valid;
    bit adv_pending, outstanding;
    // scoreboard of the expected cycle-level behaviour
    bit in_sweep;
    int writes, advs, exp_count;
    bit e_rdreq, e_wr, e_adv, e_done;
    bit n_rdreq, n_wr, n_adv, n_done;
    // test controls and observed counters
    bit fast, timing_check, hold_valid, spurious, drive_start, restart_cell5, restart_done;
    bit sweep_evt, hs_evt;
    int ready_hold, held_cnt, cycles, first_rd, wr_seen, adv_seen, done_seen;

    task automatic model_reset();
        in_sweep = 0; writes = 0; advs = 0; exp_count = 0;
        n_rdreq = 0; n_wr = 0; n_adv = 0; n_done = 0;
        outstanding = 0; adv_pending = 0; loc = 0;
        curX = '0; curY = '0;
    endtask

    task automatic step();
        int  n_hot;
        bit  rv_real;
        bit  accept;
        @(posedge simClock);
        #1;
        cycles++;
        if (adv_pending) begin
            loc = (loc + 1) % CELLS;
            adv_pending = 0;
        end
        curX = X_bits'(loc % X_MAX);
        curY = Y_bits'(loc / X_MAX);

        e_rdreq = n_rdreq; e_wr = n_wr; e_adv = n_adv; e_done = n_done;
        if (e_done) exp_count = (exp_count + 1) % 65536;

        n_hot = int'(rd_req) + int'(wr_en) + int'(advance) + int'(done);
        check_eq("one_hot", 32'(n_hot <= 1), 32'd1);
        check_eq("rd_req", 32'(rd_req), 32'(e_rdreq));
        check_eq("wr_en", 32'(wr_en), 32'(e_wr));
        check_eq("advance", 32'(advance), 32'(e_adv));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("busy", 32'(busy), 32'(in_sweep));
        check_eq("sweep_count", 32'(sweep_count), exp_count);
        if (e_wr) begin
            check_eq("wr_x", 32'(wr_x), writes % X_MAX);
            check_eq("wr_y", 32'(wr_y), writes / X_MAX);
            check_eq("wr_data", 32'(wr_data), decay_ref(mem[writes]));
            mem[writes] = decay_ref(mem[writes]);
            writes++;
        end
        if (e_adv) advs++;
        if (advance) adv_pending = 1;
        if (rd_req && first_rd < 0) first_rd = cycles;
        wr_seen   += int'(wr_en);
        adv_seen  += int'(advance);
        done_seen += int'(done);
        if (done && timing_check) check_eq("sweep_cycles", cycles - first_rd, 32'd64);
        if (e_done) sweep_evt = 1;

        start = drive_start;
        drive_start = 0;
        if (restart_cell5 && in_sweep && writes == 4 && !restart_done) begin
            start = 1;
            restart_done = 1;
        end
        accept = start && !in_sweep;

        rv_real = 0;
        rd_valid = 0;
        rd_data = PW'($urandom);
        if (outstanding) begin
            if (!hold_valid) begin
                if (vdelay == 0) begin
                    rd_valid = 1;
                    rd_data = PW'(mem[hs_addr]);
                    outstanding = 0;
                    rv_real = 1;
                end else begin
                    vdelay--;
                end
            end
        end else if (inject_valid == 0) begin
            rd_valid = 1;
        end else if (spurious && $urandom_range(0, 3) == 0) begin
            rd_valid = 1;
        end
        if (inject_valid >= 0) inject_valid--;

        if (e_rdreq && ready_hold > 0) begin
            rd_ready = 0;
            ready_hold--;
            if (rd_req) held_cnt++;
        end else if (fast) begin
            rd_ready = 1;
        end else begin
            rd_ready = ($urandom_range(0, 1) == 1);
        end
        hs_evt = 0;
        if (e_rdreq && rd_ready) begin
            outstanding = 1;
            hs_addr = loc;
            vdelay = fast ? 0 : int'($urandom_range(0, 3));
            hs_evt = 1;
        end

        n_rdreq = accept || (e_adv && advs < CELLS) || (e_rdreq && !rd_ready);
        n_wr    = rv_real;
        n_adv   = e_wr;
        n_done  = e_adv && (advs == CELLS);
        if (accept) in_sweep = 1;
        if (e_done) begin
            in_sweep = 0;
            writes = 0;
            advs = 0;
        end
    endtask

    task automatic begin_sweep();
        sweep_evt = 0; wr_seen = 0; adv_seen = 0; done_seen = 0; first_rd = -1;
        drive_start = 1;
    endtask

    task automatic sweep_until_done();
        for (int i = 0; i < 3000 && !sweep_evt; i++) step();
        check_eq("sweep_finished", 32'(sweep_evt), 32'd1);
        step();
        step();
        check_eq("writes_per_sweep", wr_seen, CELLS);
        check_eq("advances_per_sweep", adv_seen, CELLS);
        check_eq("done_pulses", done_seen, 32'd1);
    endtask

    initial begin
        RESET_SIM_N = 0; start = 0; rd_ready = 0; rd_valid = 0; rd_data = '0;
        fast = 0; timing_check = 0; hold_valid = 0; spurious = 0; drive_start = 0;
        restart_cell5 = 0; restart_done = 0; ready_hold = 0; held_cnt = 0;
        inject_valid = -1; cycles = 0; first_rd = -1; hs_addr = 0; vdelay = 0;
        model_reset();
        for (int i = 0; i < CELLS; i++) mem[i] = int'($urandom_range(0, (1 << PW) - 1));
        mem[0] = 200; mem[1] = 5; mem[2] = 1; mem[3] = 0; mem[4] = (1 << PW) - 1;

        repeat (2) @(posedge simClock);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_req", 32'(rd_req), 32'd0);
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_advance", 32'(advance), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_count", 32'(sweep_count), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_wr_xy", 32'({wr_y, wr_x}), 32'd0);
        RESET_SIM_N = 1;
        step();
        step();

        // back-to-back handshakes: 4 cycles per cell
        fast = 1;
        timing_check = 1;
        begin_sweep();
        sweep_until_done();
        timing_check = 0;

        // memory stalls the first request for 10 cycles
        begin_sweep();
        ready_hold = 10;
        held_cnt = 0;
        for (int i = 0; i < 50 && ready_hold > 0; i++) step();
        check_eq("hold_rd_req_cycles", held_cnt, 32'd10);
        check_eq("hold_no_latch_x", 32'(wr_x), X_MAX - 1);
        check_eq("hold_no_latch_y", 32'(wr_y), Y_MAX - 1);
        check_eq("hold_no_advance", adv_seen, 32'd0);
        sweep_until_done();

        // random ready/valid timing, stray rd_valid, and a start re-pulse mid-sweep
        fast = 0;
        spurious = 1;
        for (int s = 0; s < 6; s++) begin
            restart_cell5 = (s == 2);
            restart_done = 0;
            begin_sweep();
            sweep_until_done();
        end
        restart_cell5 = 0;

        // reset while waiting for read data, then a late rd_valid
        hold_valid = 1;
        begin_sweep();
        for (int i = 0; i < 200 && !hs_evt; i++) step();
        check_eq("reached_rd_wait", 32'(hs_evt), 32'd1);
        step();
        RESET_SIM_N = 0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rd_req", 32'(rd_req), 32'd0);
        check_eq("abort_count", 32'(sweep_count), 32'd0);
        check_eq("abort_wr_data", 32'(wr_data), 32'd0);
        model_reset();
        hold_valid = 0;
        wr_seen = 0;
        step();
        RESET_SIM_N = 1;
        inject_valid = 1;
        repeat (6) step();
        check_eq("abort_no_write", wr_seen, 32'd0);
        check_eq("abort_idle_busy", 32'(busy), 32'd0);

        // sweep counter wraps from 65535 to 0
        force dut.sweep_count_q = 16'hFFFF;
        exp_count = 65535;
        step();
        release dut.sweep_count_q;
        step();
        fast = 1;
        begin_sweep();
        sweep_until_done();
        check_eq("count_wrap", 32'(sweep_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
